multi_sprite_renderer: RTL and testbench

//  Parametrised successor to the single-car erase/draw control+datapath pair: on each frame tick, erases

---
 rtl/multi_sprite_renderer_pkg.sv | 16 +
 rtl/multi_sprite_renderer_if.sv | 42 ++++
 rtl/multi_sprite_renderer_scan_counter.sv | 40 ++++
 rtl/multi_sprite_renderer.sv | 198 +++++++++++++++++++
 tb/tb_multi_sprite_renderer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/multi_sprite_renderer_pkg.sv
// Shared types and helpers for the multi-sprite erase/draw renderer.
package multi_sprite_renderer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_sprite_renderer_if.sv
// Sprite/ROM/VGA-plot bundle between object logic, sprite ROM and the renderer.
interface multi_sprite_renderer_if #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 27,
    parameter int unsigned SPRITE_H    = 48,
    parameter int unsigned X_W         = 9,
    parameter int unsigned Y_W         = 8,
    parameter int unsigned COLOUR_W    = 3
) ();
    import multi_sprite_renderer_pkg::*;

    localparam int unsigned SEL_W = idx_w(NUM_SPRITES);
    localparam int unsigned PX_W  = idx_w(SPRITE_W);
    localparam int unsigned PY_W  = idx_w(SPRITE_H);

    logic                       frame_tick;
    logic [NUM_SPRITES-1:0]     sprite_en;
    logic [NUM_SPRITES*X_W-1:0] sprite_x;
    logic [NUM_SPRITES*Y_W-1:0] sprite_y;
    logic [SEL_W-1:0]           rom_sel;
    logic [PX_W-1:0]            rom_px;
    logic [PY_W-1:0]            rom_py;
    logic [COLOUR_W-1:0]        rom_colour;
    logic [X_W-1:0]             plot_x;
    logic [Y_W-1:0]             plot_y;
    logic [COLOUR_W-1:0]        plot_colour;
    logic                       plot;
    logic                       busy;
    logic                       done;
    logic                       overrun;

    modport master (
        input  frame_tick, sprite_en, sprite_x, sprite_y, rom_colour,
        output rom_sel, rom_px, rom_py, plot_x, plot_y, plot_colour, plot, busy, done, overrun
    );

    modport slave (
        output frame_tick, sprite_en, sprite_x, sprite_y, rom_colour,
        input  rom_sel, rom_px, rom_py, plot_x, plot_y, plot_colour, plot, busy, done, overrun
    );

endinterface

// File: rtl/multi_sprite_renderer_scan_counter.sv
// Row-major (px fastest) pixel scan counter with clear, enable, wrap and last-pixel flag.
module multi_sprite_renderer_scan_counter
    import multi_sprite_renderer_pkg::*;
#(
    parameter int unsigned SPRITE_W = 27,
    parameter int unsigned SPRITE_H = 48,
    localparam int unsigned PX_W = idx_w(SPRITE_W),
    localparam int unsigned PY_W = idx_w(SPRITE_H)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    output logic [PX_W-1:0] px,
    output logic [PY_W-1:0] py,
    output logic            last_c
);

    logic px_end_c;
    logic py_end_c;

    assign px_end_c = (px == PX_W'(SPRITE_W - 1));
    assign py_end_c = (py == PY_W'(SPRITE_H - 1));
    assign last_c   = px_end_c && py_end_c;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            px <= '0;
            py <= '0;
        end else if (en) begin
            if (px_end_c) begin
                px <= '0;
                py <= py_end_c ? '0 : py + PY_W'(1);
            end else begin
                px <= px + PX_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_sprite_renderer.sv
// Per-frame erase-all-then-draw-all sprite renderer driving the VGA plot port.
// Optional build macro: SPRITE_TRANSPARENCY_EN (BG-coloured ROM pixels are not drawn).
module multi_sprite_renderer
    import multi_sprite_renderer_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned SPRITE_W    = 27,
    parameter int unsigned SPRITE_H    = 48,
    parameter int unsigned X_W         = 9,
    parameter int unsigned Y_W         = 8,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter int unsigned COLOUR_W    = 3,
    parameter int unsigned BG_COLOUR   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    multi_sprite_renderer_if.master  bus
);

    localparam int unsigned SEL_W = idx_w(NUM_SPRITES);
    localparam int unsigned PX_W  = idx_w(SPRITE_W);
    localparam int unsigned PY_W  = idx_w(SPRITE_H);

    state_t                     state, state_n;
    logic [SEL_W-1:0]           ch, ch_n;
    logic                       drain, drain_n;
    logic                       busy, busy_n, done, done_n, overrun;
    logic                       snap, commit, scan_clr, scan_en, scan_last_c, issue;
    logic [PX_W-1:0]            px;
    logic [PY_W-1:0]            py;
    logic [NUM_SPRITES-1:0]     new_en, old_valid;
    logic [NUM_SPRITES*X_W-1:0] new_x, old_x;
    logic [NUM_SPRITES*Y_W-1:0] new_y, old_y;
    logic [SEL_W:0]             first_old, first_new, first_in, next_old, next_new;
    logic [X_W-1:0]             base_x;
    logic [Y_W-1:0]             base_y;
    logic [X_W:0]               x_sum;
    logic [Y_W:0]               y_sum;
    logic                       clip_x, clip_y;
    logic                       plot_q, draw_q;
    logic [X_W-1:0]             plot_x;
    logic [Y_W-1:0]             plot_y;

    // Returns {found, index} of the lowest set bit of mask at or above 'from'.
    function automatic logic [SEL_W:0] next_set(input logic [NUM_SPRITES-1:0] mask, input int from);
        logic [SEL_W:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
            if (mask[i] && i >= from && !r[SEL_W]) r = {1'b1, SEL_W'(i)};
        end
        return r;
    endfunction

    multi_sprite_renderer_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
        .clock (clock),
        .reset (reset),
        .clear (scan_clr),
        .en    (scan_en),
        .px    (px),
        .py    (py),
        .last_c(scan_last_c)
    );

    assign first_old = next_set(old_valid, 0);
    assign first_new = next_set(new_en, 0);
    assign first_in  = next_set(bus.sprite_en, 0);
    assign next_old  = next_set(old_valid, int'(ch) + 1);
    assign next_new  = next_set(new_en, int'(ch) + 1);

    // Phase sequencing; empty channels are skipped without spending a cycle.
    always_comb begin
        state_n  = state;
        ch_n     = ch;
        drain_n  = drain;
        busy_n   = busy;
        done_n   = 1'b0;
        snap     = 1'b0;
        commit   = 1'b0;
        scan_clr = 1'b0;
        scan_en  = 1'b0;
        case (state)
            IDLE: if (bus.frame_tick) begin
                snap     = 1'b1;
                busy_n   = 1'b1;
                scan_clr = 1'b1;
                if (first_old[SEL_W]) begin
                    state_n = ERASE;
                    ch_n    = first_old[SEL_W-1:0];
                end else begin
                    state_n = DRAW;
                    ch_n    = first_in[SEL_W-1:0];
                    drain_n = !first_in[SEL_W];
                end
            end
            ERASE: begin
                scan_en = 1'b1;
                if (scan_last_c) begin
                    if (next_old[SEL_W]) begin
                        ch_n = next_old[SEL_W-1:0];
                    end else begin
                        state_n = DRAW;
                        ch_n    = first_new[SEL_W-1:0];
                        drain_n = !first_new[SEL_W];
                    end
                end
            end
            DRAW: begin
                if (drain) begin
                    state_n = FINISH;
                    drain_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    scan_en = 1'b1;
                    if (scan_last_c) begin
                        if (next_new[SEL_W]) ch_n = next_new[SEL_W-1:0];
                        else                 drain_n = 1'b1;
                    end
                end
            end
            FINISH: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign issue  = (state == ERASE || state == DRAW) && !drain;
    assign base_x = (state == ERASE) ? old_x[ch*X_W +: X_W] : new_x[ch*X_W +: X_W];
    assign base_y = (state == ERASE) ? old_y[ch*Y_W +: Y_W] : new_y[ch*Y_W +: Y_W];
    assign x_sum  = {1'b0, base_x} + (X_W+1)'(px);
    assign y_sum  = {1'b0, base_y} + (Y_W+1)'(py);
    assign clip_x = x_sum[X_W] || (x_sum >= (X_W+1)'(SCREEN_W));
    assign clip_y = y_sum[Y_W] || (y_sum >= (Y_W+1)'(SCREEN_H));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            drain     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            new_en    <= '0;
            new_x     <= '0;
            new_y     <= '0;
            old_valid <= '0;
            old_x     <= '0;
            old_y     <= '0;
            plot_q    <= 1'b0;
            draw_q    <= 1'b0;
            plot_x    <= '0;
            plot_y    <= '0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            drain  <= drain_n;
            busy   <= busy_n;
            done   <= done_n;
            plot_q <= issue && !clip_x && !clip_y;
            if (bus.frame_tick && busy) overrun <= 1'b1;
            if (snap) begin
                new_en <= bus.sprite_en;
                new_x  <= bus.sprite_x;
                new_y  <= bus.sprite_y;
            end
            if (commit) begin
                old_valid <= new_en;
                old_x     <= new_x;
                old_y     <= new_y;
            end
            if (issue) begin
                plot_x <= x_sum[X_W-1:0];
                plot_y <= y_sum[Y_W-1:0];
                draw_q <= (state == DRAW);
            end
        end
    end

    assign bus.rom_sel  = ch;
    assign bus.rom_px   = px;
    assign bus.rom_py   = py;
    assign bus.plot_x   = plot_x;
    assign bus.plot_y   = plot_y;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.overrun  = overrun;
    // ROM data lands in the same cycle as the registered plot strobe, so colour is muxed in directly.
    assign bus.plot_colour = draw_q ? bus.rom_colour : COLOUR_W'(BG_COLOUR);
`ifdef SPRITE_TRANSPARENCY_EN
    assign bus.plot = plot_q && !(draw_q && (bus.rom_colour == COLOUR_W'(BG_COLOUR)));
`else
    assign bus.plot = plot_q;
`endif

endmodule

// File: tb/tb_multi_sprite_renderer.sv
// Directed bench for multi_sprite_renderer with a 2-channel, 2x2-pixel configuration.
module tb_multi_sprite_renderer;
    import multi_sprite_renderer_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned SH = 2;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_sprite_renderer_if #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
                               .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    multi_sprite_renderer #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .X_W(XW), .Y_W(YW),
                            .SCREEN_W(320), .SCREEN_H(240), .COLOUR_W(CW), .BG_COLOUR(0)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sprite ROM contents indexed {sel, py, px}; channel 0 pixel (1,0) is background.
    function automatic int rom_val(input int ch, input int px, input int py);
        logic [2:0] k;
        k = {ch[0], py[0], px[0]};
        case (k)
            3'b000: return 5;
            3'b001: return 0;
            3'b010: return 3;
            3'b011: return 6;
            3'b100: return 7;
            3'b101: return 2;
            3'b110: return 4;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) bus.rom_colour <= CW'(rom_val(int'(bus.rom_sel), int'(bus.rom_px), int'(bus.rom_py)));

    task automatic add_sprite(input int x, input int y, input int ch, input bit draw);
        pix_t p;
        for (int py = 0; py < int'(SH); py++) begin
            for (int px = 0; px < int'(SW); px++) begin
                p.x = x + px;
                p.y = y + py;
                p.c = draw ? rom_val(ch, px, py) : 0;
                if (p.x >= 320 || p.y >= 240) continue;
`ifdef SPRITE_TRANSPARENCY_EN
                if (draw && p.c == 0) continue;
`endif
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic set_sprite(input int ch, input int x, input int y);
        bus.sprite_x[ch*XW +: XW] = XW'(x);
        bus.sprite_y[ch*YW +: YW] = YW'(y);
    endtask

    task automatic run_frame(input string tag, input int extra_at, input int exp_cycles);
        pix_t p;
        int   cyc;
        cyc = 0;
        got_q.delete();
        @(posedge clk); #1 bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.frame_tick = 1'b0;
        for (int n = 1; n <= 200 && cyc == 0; n++) begin
            @(negedge clk);
            if (n == 1) check_val({tag, "_busy"}, int'(bus.busy), 1);
            bus.frame_tick = (n == extra_at);
            if (bus.plot) begin
                p.x = int'(bus.plot_x);
                p.y = int'(bus.plot_y);
                p.c = int'(bus.plot_colour);
                got_q.push_back(p);
            end
            if (bus.done) begin
                cyc = n;
                check_val({tag, "_busy_at_done"}, int'(bus.busy), 0);
            end
        end
        bus.frame_tick = 1'b0;
        check_val({tag, "_cycles"}, cyc, exp_cycles);
        check_val({tag, "_nplots"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val($sformatf("%s_p%0d_x", tag, i), got_q[i].x, exp_q[i].x);
            check_val($sformatf("%s_p%0d_y", tag, i), got_q[i].y, exp_q[i].y);
            check_val($sformatf("%s_p%0d_c", tag, i), got_q[i].c, exp_q[i].c);
        end
        exp_q.delete();
    endtask

    initial begin
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.sprite_en  = '0;
        bus.sprite_x   = '0;
        bus.sprite_y   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_plot", int'(bus.plot), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_done", int'(bus.done), 0);
        check_val("rst_overrun", int'(bus.overrun), 0);
        @(posedge clk); #1 rst = 1'b0;

        // First frame: nothing to erase, four draws.
        bus.sprite_en = 2'b01;
        set_sprite(0, 10, 20);
        add_sprite(10, 20, 0, 1'b1);
        run_frame("t1", 0, 6);
        check_val("t1_overrun", int'(bus.overrun), 0);

        // Move: erase old footprint, then draw at new position.
        set_sprite(0, 12, 20);
        add_sprite(10, 20, 0, 1'b0);
        add_sprite(12, 20, 0, 1'b1);
        run_frame("t2", 0, 10);
        check_val("t2_overrun", int'(bus.overrun), 0);

        // Channel 1 at the bottom-right corner: three of its pixels are clipped.
        bus.sprite_en = 2'b11;
        set_sprite(1, 319, 239);
        add_sprite(12, 20, 0, 1'b0);
        add_sprite(12, 20, 0, 1'b1);
        add_sprite(319, 239, 1, 1'b1);
        run_frame("t3", 0, 14);

        // Second tick while busy is ignored but flagged.
        add_sprite(12, 20, 0, 1'b0);
        add_sprite(319, 239, 1, 1'b0);
        add_sprite(12, 20, 0, 1'b1);
        add_sprite(319, 239, 1, 1'b1);
        run_frame("t4", 2, 18);
        check_val("t4_overrun", int'(bus.overrun), 1);

        // Reset in the middle of the draw phase.
        @(posedge clk); #1 bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.frame_tick = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t5_mid_plot", int'(bus.plot), 1);
        check_val("t5_mid_overrun", int'(bus.overrun), 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_rst_plot", int'(bus.plot), 0);
        check_val("t5_rst_busy", int'(bus.busy), 0);
        check_val("t5_rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;

        // After reset the old positions are forgotten: draw only.
        bus.sprite_en = 2'b01;
        set_sprite(0, 10, 20);
        add_sprite(10, 20, 0, 1'b1);
        run_frame("t5b", 0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
